traffic_sensor_conditioner: RTL and testbench
=============================================

// Module: traffic_sensor_conditioner
// PURPOSE
//  Conditions the two raw road-loop detector inputs (street A, street B) into the clean
//  SA/SB car-present signals that the traffic-light FSM consumes. Per street: 2-FF
//  synchronizer, debounce state machine, release hold-off, and 1-cycle arrival pulse.
//  Sits between the board-level detector pins and the FSM sensor inputs; same clock domain as the FSM.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   cycles raw input must stay high (post-sync) before presence is declared; >=1
//  HOLD_CYCLES      8   cycles presence is held after the loop releases; >=1
//  CNT_W            8   width of per-street arrival counters (SENSOR_COUNT_EN only)
// PORTS
//  clock    in   1      single system clock, all logic on posedge
//  reset    in   1      synchronous, active-high; clears all state on the next posedge
//  raw_a    in   1      street A loop detector, asynchronous, may bounce
//  raw_b    in   1      street B loop detector, asynchronous, may bounce
//  cnt_clr  in   1      synchronous clear of both arrival counters
//  sa       out  1      street A car present (to FSM SA)
//  sb       out  1      street B car present (to FSM SB)
//  arr_a    out  1      1-cycle pulse: new street A arrival
//  arr_b    out  1      1-cycle pulse: new street B arrival
//  cnt_a    out  CNT_W  street A arrivals since reset/clear
//  cnt_b    out  CNT_W  street B arrivals since reset/clear
// BEHAVIOUR
//  Reset: sync flops 0, state IDLE, timers 0, counters 0; sa=sb=arr_a=arr_b=0, cnt_a=cnt_b=0.
//  Reset asserted mid-debounce or mid-hold: abandons operation, all of the above on next edge.
//  Channels A and B are identical and fully independent; s = 2nd synchronizer stage.
//  States per channel (timer t, width clog2(max(D,H)+1)):
//   IDLE:    out=0. s=1 -> ARMING, t=0.
//   ARMING:  out=0. s=0 -> IDLE. s=1 and t==DEBOUNCE_CYCLES-1 -> PRESENT, arrival pulse; else t++.
//   PRESENT: out=1. s=0 -> HOLD, t=0.
//   HOLD:    out=1. s=1 -> PRESENT (no arrival pulse). t==HOLD_CYCLES-1 -> IDLE; else t++.
//  sa/sb decoded from the state register: 1 in PRESENT or HOLD.
//  arr_x registered: high exactly the cycle after the ARMING->PRESENT edge, for 1 cycle.
//  Latency: raw held high from before edge 1 -> sa high after edge DEBOUNCE_CYCLES+3.
//  Release: raw low from before edge 1 -> sa low after edge HOLD_CYCLES+3.
//  Glitch shorter than DEBOUNCE_CYCLES post-sync cycles: sa and arr stay 0.
//  Re-press during HOLD: sa never drops, no new arrival counted.
// CONFIGURATION
//  Macro SENSOR_COUNT_EN:
//   defined: cnt_x increments on each arr_x pulse; saturates at all-ones (no wrap);
//    cnt_clr clears both; cnt_clr coincident with arr_x -> cnt_x = 1.
//   undefined: counters not built; cnt_a=cnt_b=0 constantly; cnt_clr ignored;
//    sa/sb/arr behaviour unchanged.
// STRUCTURE
//  Package traffic_pkg: typedef enum logic [1:0] {SNS_IDLE, SNS_ARMING, SNS_PRESENT,
//   SNS_HOLD} sns_state_t; default DEBOUNCE_CYCLES / HOLD_CYCLES constants.
//  Sub-module sensor_channel (sync + FSM + timer + arrival pulse + optional counter),
//   instantiated twice (A, B); top is wiring only.
// TESTING (D=4, H=8, CNT_W=8, SENSOR_COUNT_EN defined unless stated)
//  1. reset=1 for 3 cycles with raw_a=raw_b=1 -> sa=sb=arr=0, cnt=0; release, raw_a held -> sa=1 at edge 7.
//  2. raw_a high 3 cycles then low -> sa stays 0, arr_a never pulses, cnt_a=0.
//  3. raw_a high 10 cycles then low -> one arr_a pulse, cnt_a=1, sa falls 11 edges after raw_a falls.
//  4. raw_a high, low 4 cycles (in HOLD), high again -> sa stays 1 throughout, cnt_a remains 1.
//  5. 260 clean arrivals on raw_b -> cnt_b saturates at 255; cnt_clr with arrival -> cnt_b=1.
//  6. reset pulsed mid-HOLD -> next edge sa=0, state IDLE; macro undefined -> cnt_a=cnt_b=0 always.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the road-loop sensor conditioner.
package traffic_pkg;

   typedef enum logic [1:0] {
      SNS_IDLE,
      SNS_ARMING,
      SNS_PRESENT,
      SNS_HOLD
   } sns_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int DEFAULT_HOLD_CYCLES     = 8;
   localparam int DEFAULT_CNT_W           = 8;

   function automatic int sns_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sensor_channel.sv
// One loop-detector channel: 2-FF synchronizer, debounce/hold FSM, arrival pulse and,
// when SENSOR_COUNT_EN is defined, a saturating arrival counter.
module sensor_channel
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             raw,
   input  logic             cnt_clr,
   output logic             present,
   output logic             arrival,
   output logic [CNT_W-1:0] count
);

   localparam int TW = $clog2(sns_max(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1);
   localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   sns_state_t    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          arr_q, arr_d;

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      state_d = state_q;
      timer_d = timer_q;
      arr_d   = 1'b0;
      case (state_q)
         SNS_IDLE: begin
            if (sync2_q) begin
               state_d = SNS_ARMING;
               timer_d = '0;
            end
         end
         SNS_ARMING: begin
            if (!sync2_q) begin
               state_d = SNS_IDLE;
            end else if (timer_q == DEB_LAST) begin
               state_d = SNS_PRESENT;
               arr_d   = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         SNS_PRESENT: begin
            if (!sync2_q) begin
               state_d = SNS_HOLD;
               timer_d = '0;
            end
         end
         SNS_HOLD: begin
            // A re-press wins over hold expiry and is not a new arrival.
            if (sync2_q) begin
               state_d = SNS_PRESENT;
            end else if (timer_q == HOLD_LAST) begin
               state_d = SNS_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = SNS_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= SNS_IDLE;
         timer_q <= '0;
         arr_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         timer_q <= timer_d;
         arr_q   <= arr_d;
      end
   end

   assign present = (state_q == SNS_PRESENT) || (state_q == SNS_HOLD);
   assign arrival = arr_q;

`ifdef SENSOR_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts the registered pulse; a clear in the same cycle keeps that arrival.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = arr_q ? CNT_W'(1) : '0;
      end else if (arr_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign count          = '0;
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the street A/B loop detectors into SA/SB presence and arrival signals.
// Arrival counters exist only when SENSOR_COUNT_EN is defined.
module traffic_sensor_conditioner
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             raw_a,
   input  logic             raw_b,
   input  logic             cnt_clr,
   output logic             sa,
   output logic             sb,
   output logic             arr_a,
   output logic             arr_b,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   sensor_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .CNT_W          (CNT_W)
   ) u_chan_a (
      .clock  (clock),
      .reset  (reset),
      .raw    (raw_a),
      .cnt_clr(cnt_clr),
      .present(sa),
      .arrival(arr_a),
      .count  (cnt_a)
   );

   sensor_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .CNT_W          (CNT_W)
   ) u_chan_b (
      .clock  (clock),
      .reset  (reset),
      .raw    (raw_b),
      .cnt_clr(cnt_clr),
      .present(sb),
      .arrival(arr_b),
      .count  (cnt_b)
   );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed self-checking bench for traffic_sensor_conditioner (D=4, H=8, CNT_W=8);
// counter expectations follow whether SENSOR_COUNT_EN is defined.
module tb_traffic_sensor_conditioner;

   logic       clock;
   logic       reset;
   logic       raw_a;
   logic       raw_b;
   logic       cnt_clr;
   logic       sa;
   logic       sb;
   logic       arr_a;
   logic       arr_b;
   logic [7:0] cnt_a;
   logic [7:0] cnt_b;

   int checks;
   int failures;
   int arrACount;
   int arrBCount;
   int seenFlag;

   traffic_sensor_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES    (8),
      .CNT_W          (8)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .raw_a  (raw_a),
      .raw_b  (raw_b),
      .cnt_clr(cnt_clr),
      .sa     (sa),
      .sb     (sb),
      .arr_a  (arr_a),
      .arr_b  (arr_b),
      .cnt_a  (cnt_a),
      .cnt_b  (cnt_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

`ifdef SENSOR_COUNT_EN
   function automatic int expCnt(input int v);
      return v;
   endfunction
`else
   function automatic int expCnt(input int v);
      return (v < 0) ? v : 0;
   endfunction
`endif

   // Advance n clock edges; sampling happens 1 time unit after each edge.
   task automatic stepCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         arrACount += int'(arr_a);
         arrBCount += int'(arr_b);
      end
   endtask

   task automatic applyStimulus(input logic ra, input logic rb, input logic clr, input int n);
      raw_a   = ra;
      raw_b   = rb;
      cnt_clr = clr;
      stepCycles(n);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyReset();
      raw_a   = 1'b0;
      raw_b   = 1'b0;
      cnt_clr = 1'b0;
      reset   = 1'b1;
      stepCycles(2);
      reset     = 1'b0;
      arrACount = 0;
      arrBCount = 0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      arrACount = 0;
      arrBCount = 0;
      reset     = 1'b1;
      raw_a     = 1'b1;
      raw_b     = 1'b1;
      cnt_clr   = 1'b0;

      $display("[TB] test 1: reset with inputs high, then debounce latency");
      stepCycles(3);
      checkOutput("rst_sa", 32'(sa), 0);
      checkOutput("rst_sb", 32'(sb), 0);
      checkOutput("rst_arr_a", 32'(arr_a), 0);
      checkOutput("rst_arr_b", 32'(arr_b), 0);
      checkOutput("rst_cnt_a", 32'(cnt_a), 0);
      checkOutput("rst_cnt_b", 32'(cnt_b), 0);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 6);
      checkOutput("lat_sa_edge6", 32'(sa), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("lat_sa_edge7", 32'(sa), 1);
      checkOutput("lat_arr_a_edge7", 32'(arr_a), 1);
      checkOutput("lat_sb_idle", 32'(sb), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("lat_arr_a_edge8", 32'(arr_a), 0);
      checkOutput("lat_cnt_a", 32'(cnt_a), 32'(expCnt(1)));

      $display("[TB] test 2: short glitch is rejected");
      applyReset();
      seenFlag = 0;
      for (int i = 0; i < 18; i++) begin
         applyStimulus((i < 3), 1'b0, 1'b0, 1);
         seenFlag |= int'(sa);
      end
      checkOutput("glitch_sa", 32'(seenFlag), 0);
      checkOutput("glitch_arr_a", 32'(arrACount), 0);
      checkOutput("glitch_cnt_a", 32'(cnt_a), 0);

      $display("[TB] test 3: long press and release timing");
      applyReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 10);
      checkOutput("press_sa", 32'(sa), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 10);
      checkOutput("release_sa_edge10", 32'(sa), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      checkOutput("release_sa_edge11", 32'(sa), 0);
      checkOutput("press_arr_pulses", 32'(arrACount), 1);
      checkOutput("press_cnt_a", 32'(cnt_a), 32'(expCnt(1)));

      $display("[TB] test 4: re-press during hold");
      applyReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 10);
      seenFlag = 0;
      for (int i = 0; i < 14; i++) begin
         applyStimulus((i >= 4), 1'b0, 1'b0, 1);
         seenFlag |= int'(!sa);
      end
      checkOutput("repress_sa_drop", 32'(seenFlag), 0);
      checkOutput("repress_arr_pulses", 32'(arrACount), 1);
      checkOutput("repress_cnt_a", 32'(cnt_a), 32'(expCnt(1)));

      $display("[TB] test 5: counter saturation and clear");
      applyReset();
      for (int k = 0; k < 260; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8);
         applyStimulus(1'b0, 1'b0, 1'b0, 12);
         if (k == 253) checkOutput("sat_cnt_b_254", 32'(cnt_b), 32'(expCnt(254)));
         if (k == 254) checkOutput("sat_cnt_b_255", 32'(cnt_b), 32'(expCnt(255)));
      end
      checkOutput("sat_cnt_b_260", 32'(cnt_b), 32'(expCnt(255)));
      checkOutput("sat_arr_b_pulses", 32'(arrBCount), 260);
      checkOutput("sat_cnt_a_indep", 32'(cnt_a), 0);
      checkOutput("sat_arr_a_indep", 32'(arrACount), 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 7);
      checkOutput("clr_arr_b", 32'(arr_b), 1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1);
      checkOutput("clr_with_arr_cnt_b", 32'(cnt_b), 32'(expCnt(1)));
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      checkOutput("clr_only_cnt_b", 32'(cnt_b), 0);
      cnt_clr = 1'b0;

      $display("[TB] test 6: reset during hold");
      applyReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 10);
      applyStimulus(1'b0, 1'b0, 1'b0, 5);
      checkOutput("hold_sa_before_rst", 32'(sa), 1);
      checkOutput("hold_cnt_a_before_rst", 32'(cnt_a), 32'(expCnt(1)));
      reset = 1'b1;
      stepCycles(1);
      checkOutput("hold_rst_sa", 32'(sa), 0);
      checkOutput("hold_rst_state", 32'(dut.u_chan_a.state_q), 32'(traffic_pkg::SNS_IDLE));
      checkOutput("hold_rst_cnt_a", 32'(cnt_a), 0);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 6);
      checkOutput("after_rst_sa_edge6", 32'(sa), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("after_rst_sa_edge7", 32'(sa), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
